// File: rtl/pwl_exp_pipe.sv
// Piecewise-linear BF16 exp approximation: per-lane classify, table lookup, base + M*slope.
// Three registered stages, 3-cycle latency; a stalled output (out_valid & !out_ready) freezes every stage.
module pwl_exp_pipe #(
  parameter int          LANES     = 1,
  parameter int          EMIN      = -7,
  parameter int          EMAX      = 6,
  parameter int          ROUND     = 0,
  parameter logic [15:0] SAT_POS   = 16'h7F80,
  parameter logic [15:0] SAT_NEG   = 16'hFF80,
  parameter logic [15:0] SMALL_VAL = 16'h0000,
  parameter logic [15:0] QNAN      = 16'h7FC0,
  localparam int         D         = EMAX - EMIN,
  localparam int         IW        = (D > 1) ? $clog2(D) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*LANES-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*LANES-1:0]   out_data,
  input  logic                  cfg_w_en,
  input  logic                  cfg_sgn,
  input  logic [IW-1:0]         cfg_idx,
  input  logic [15:0]           cfg_base,
  input  logic [15:0]           cfg_offset,
  output logic [1:0]            inflight
);

  typedef enum logic [1:0] {CLS_RANGE, CLS_SMALL, CLS_BIG, CLS_NAN} cls_e;

  localparam logic [7:0]  E_LO  = 8'(127 + EMIN);
  localparam logic [7:0]  E_HI  = 8'(127 + EMAX);
  localparam logic [IW:0] D_LIM = (IW + 1)'(D);

  logic stall;
  logic adv;

  // Coefficient table, deliberately left out of reset so configuration survives it.
  logic [15:0] base_q   [2][D];
  logic [15:0] base_d   [2][D];
  logic [15:0] offset_q [2][D];
  logic [15:0] offset_d [2][D];

  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;

  cls_e        s1_cls_q [LANES];
  cls_e        s1_cls_d [LANES];
  logic        s1_sgn_q [LANES];
  logic        s1_sgn_d [LANES];
  logic [IW-1:0] s1_idx_q [LANES];
  logic [IW-1:0] s1_idx_d [LANES];
  logic [6:0]  s1_man_q [LANES];
  logic [6:0]  s1_man_d [LANES];

  cls_e        s2_cls_q  [LANES];
  cls_e        s2_cls_d  [LANES];
  logic        s2_sgn_q  [LANES];
  logic        s2_sgn_d  [LANES];
  logic [15:0] s2_base_q [LANES];
  logic [15:0] s2_base_d [LANES];
  logic [22:0] s2_prod_q [LANES];
  logic [22:0] s2_prod_d [LANES];

  logic [16*LANES-1:0] out_data_q, out_data_d;

  assign stall     = v3_q & ~out_ready;
  assign adv       = ~stall;
  assign in_ready  = adv;
  assign out_valid = v3_q;
  assign out_data  = out_data_q;
  assign inflight  = {1'b0, v1_q} + {1'b0, v2_q} + {1'b0, v3_q};

  always_comb begin
    base_d   = base_q;
    offset_d = offset_q;
    if (cfg_w_en && ({1'b0, cfg_idx} < D_LIM)) begin
      base_d[cfg_sgn][cfg_idx]   = cfg_base;
      offset_d[cfg_sgn][cfg_idx] = cfg_offset;
    end
  end

  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    v3_d = v3_q;
    if (adv) begin
      v1_d = in_valid;
      v2_d = v1_q;
      v3_d = v2_q;
    end
  end

  // S1: decode and classify; non-range lanes carry index 0 so the S2 read stays in bounds.
  always_comb begin
    logic [7:0] e;
    logic [6:0] m;
    cls_e       cls;
    e   = '0;
    m   = '0;
    cls = CLS_RANGE;
    for (int l = 0; l < LANES; l++) begin
      s1_cls_d[l] = s1_cls_q[l];
      s1_sgn_d[l] = s1_sgn_q[l];
      s1_idx_d[l] = s1_idx_q[l];
      s1_man_d[l] = s1_man_q[l];
      e = in_data[16*l+7 +: 8];
      m = in_data[16*l +: 7];
      if (e == 8'hFF && m != 7'd0) begin
        cls = CLS_NAN;
      end else if (e >= E_HI) begin
        cls = CLS_BIG;
      end else if (e < E_LO) begin
        cls = CLS_SMALL;
      end else begin
        cls = CLS_RANGE;
      end
      if (adv) begin
        s1_cls_d[l] = cls;
        s1_sgn_d[l] = in_data[16*l+15];
        s1_man_d[l] = m;
        s1_idx_d[l] = (cls == CLS_RANGE) ? IW'(e - E_LO) : '0;
      end
    end
  end

  // S2: table read and multiply; a held product is never recomputed while stalled.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      s2_cls_d[l]  = s2_cls_q[l];
      s2_sgn_d[l]  = s2_sgn_q[l];
      s2_base_d[l] = s2_base_q[l];
      s2_prod_d[l] = s2_prod_q[l];
      if (adv) begin
        s2_cls_d[l]  = s1_cls_q[l];
        s2_sgn_d[l]  = s1_sgn_q[l];
        s2_base_d[l] = base_q[s1_sgn_q[l]][s1_idx_q[l]];
        s2_prod_d[l] = 23'(s1_man_q[l]) * 23'(offset_q[s1_sgn_q[l]][s1_idx_q[l]]);
      end
    end
  end

  // S3: add, select by class; only real beats overwrite the output register.
  always_comb begin
    logic [15:0] y;
    logic [15:0] rnd;
    out_data_d = out_data_q;
    y          = '0;
    rnd        = '0;
    for (int l = 0; l < LANES; l++) begin
      rnd = (ROUND != 0) ? {15'd0, s2_prod_q[l][6]} : 16'd0;
      y   = s2_base_q[l] + s2_prod_q[l][22:7] + rnd;
      if (adv && v2_q) begin
        case (s2_cls_q[l])
          CLS_NAN:   out_data_d[16*l +: 16] = QNAN;
          CLS_BIG:   out_data_d[16*l +: 16] = s2_sgn_q[l] ? SAT_NEG : SAT_POS;
          CLS_SMALL: out_data_d[16*l +: 16] = SMALL_VAL;
          default:   out_data_d[16*l +: 16] = y;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      v3_q       <= 1'b0;
      out_data_q <= '0;
    end else begin
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      v3_q       <= v3_d;
      out_data_q <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    base_q    <= base_d;
    offset_q  <= offset_d;
    s1_cls_q  <= s1_cls_d;
    s1_sgn_q  <= s1_sgn_d;
    s1_idx_q  <= s1_idx_d;
    s1_man_q  <= s1_man_d;
    s2_cls_q  <= s2_cls_d;
    s2_sgn_q  <= s2_sgn_d;
    s2_base_q <= s2_base_d;
    s2_prod_q <= s2_prod_d;
  end

endmodule

// File: tb/tb_pwl_exp_pipe.sv
// Directed bench for pwl_exp_pipe: a ROUND=0 and a ROUND=1 instance driven with identical stimulus.
module tb_pwl_exp_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, cfg_w_en, cfg_sgn;
  logic [15:0] in_data, cfg_base, cfg_offset;
  logic [3:0]  cfg_idx;
  logic        in_ready, out_valid, in_ready_r, out_valid_r;
  logic [15:0] out_data, out_data_r;
  logic [1:0]  inflight, inflight_r;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  pwl_exp_pipe #(.ROUND(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_w_en(cfg_w_en), .cfg_sgn(cfg_sgn), .cfg_idx(cfg_idx), .cfg_base(cfg_base),
    .cfg_offset(cfg_offset), .inflight(inflight)
  );

  pwl_exp_pipe #(.ROUND(1)) dut_r (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r), .in_data(in_data),
    .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r),
    .cfg_w_en(cfg_w_en), .cfg_sgn(cfg_sgn), .cfg_idx(cfg_idx), .cfg_base(cfg_base),
    .cfg_offset(cfg_offset), .inflight(inflight_r)
  );

  task automatic wr(input logic s, input logic [3:0] i, input logic [15:0] b, input logic [15:0] o);
    @(negedge clk);
    cfg_w_en = 1'b1; cfg_sgn = s; cfg_idx = i; cfg_base = b; cfg_offset = o;
    @(negedge clk);
    cfg_w_en = 1'b0;
  endtask

  // Sends one beat and reports what came out and how many cycles it took (-1 on timeout).
  task automatic run_beat(input logic [15:0] din, output logic [15:0] dout,
                          output logic [15:0] dout_r, output int lat);
    dout = 16'hxxxx; dout_r = 16'hxxxx; lat = -1;
    @(negedge clk);
    in_valid = 1'b1; in_data = din;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      if (out_valid) begin
        lat = k; dout = out_data; dout_r = out_data_r;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int seen;
    rst = 1'b1; in_valid = 1'b1; in_data = 16'h3C00; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (inflight !== 2'd0) begin errors++; $display("FAIL reset_inflight got %0d want 0", inflight); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got %h want 0000", out_data); end
    checks++; if (out_valid_r !== 1'b0 || inflight_r !== 2'd0 || in_ready_r !== 1'b1)
      begin errors++; $display("FAIL reset_round_inst got v=%b n=%0d r=%b want 0 0 1", out_valid_r, inflight_r, in_ready_r); end
    rst = 1'b0; in_valid = 1'b0;
    seen = 0;
    repeat (6) begin @(negedge clk); if (out_valid) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL reset_beat_captured got %0d beats want 0", seen); end
  endtask

  task automatic test_basic();
    logic [15:0] d, dr; int lat;
    wr(1'b0, 4'd0, 16'h3F80, 16'h0100);
    run_beat(16'h3C00, d, dr, lat);
    checks++; if (d !== 16'h3F80) begin errors++; $display("FAIL basic_3c00 got %h want 3f80", d); end
    checks++; if (lat != 3) begin errors++; $display("FAIL basic_latency got %0d want 3", lat); end
    run_beat(16'h3C40, d, dr, lat);
    checks++; if (d !== 16'h4000) begin errors++; $display("FAIL basic_3c40 got %h want 4000", d); end
    checks++; if (dr !== 16'h4000) begin errors++; $display("FAIL basic_3c40_round got %h want 4000", dr); end
    checks++; if (lat != 3) begin errors++; $display("FAIL basic_latency2 got %0d want 3", lat); end
  endtask

  task automatic test_round();
    logic [15:0] d, dr; int lat;
    wr(1'b0, 4'd0, 16'h3F80, 16'h0101);
    run_beat(16'h3C40, d, dr, lat);
    checks++; if (d !== 16'h4000) begin errors++; $display("FAIL round0 got %h want 4000", d); end
    checks++; if (dr !== 16'h4001) begin errors++; $display("FAIL round1 got %h want 4001", dr); end
    wr(1'b0, 4'd0, 16'h3F80, 16'h0100);
  endtask

  task automatic test_classes();
    logic [15:0] vin [8];
    logic [15:0] vexp [8];
    logic [15:0] d, dr; int lat;
    vin = '{16'h4300, 16'hC300, 16'h7F80, 16'h3B80, 16'h0000, 16'h7FC1, 16'h4280, 16'hBB80};
    vexp = '{16'h7F80, 16'hFF80, 16'h7F80, 16'h0000, 16'h0000, 16'h7FC0, 16'h7F80, 16'h0000};
    for (int i = 0; i < 8; i++) begin
      run_beat(vin[i], d, dr, lat);
      checks++; if (d !== vexp[i]) begin errors++; $display("FAIL class_%h got %h want %h", vin[i], d, vexp[i]); end
    end
    wr(1'b1, 4'd2, 16'h1234, 16'h0100);
    run_beat(16'hBD03, d, dr, lat);
    checks++; if (d !== 16'h123A) begin errors++; $display("FAIL neg_half_idx2 got %h want 123a", d); end
    wr(1'b0, 4'd12, 16'h5000, 16'h0000);
    run_beat(16'h4200, d, dr, lat);
    checks++; if (d !== 16'h5000) begin errors++; $display("FAIL top_idx12 got %h want 5000", d); end
  endtask

  task automatic test_idx_oob();
    logic [15:0] d, dr; int lat;
    wr(1'b0, 4'd13, 16'hDEAD, 16'hFFFF);
    wr(1'b1, 4'd15, 16'hBEEF, 16'hFFFF);
    run_beat(16'h3C00, d, dr, lat);
    checks++; if (d !== 16'h3F80) begin errors++; $display("FAIL oob_idx0 got %h want 3f80", d); end
    run_beat(16'h4200, d, dr, lat);
    checks++; if (d !== 16'h5000) begin errors++; $display("FAIL oob_idx12 got %h want 5000", d); end
    run_beat(16'hBD03, d, dr, lat);
    checks++; if (d !== 16'h123A) begin errors++; $display("FAIL oob_neg_idx2 got %h want 123a", d); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vin [3];
    logic [15:0] vexp [3];
    logic [15:0] got [3];
    int got_k [3];
    int n;
    vin = '{16'h3C00, 16'h3C40, 16'h4300};
    vexp = '{16'h3F80, 16'h4000, 16'h7F80};
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = vin[0];
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (out_valid && n < 3) begin got[n] = out_data; got_k[n] = k; n++; end
      if (k < 3) in_data = vin[k];
      else in_valid = 1'b0;
    end
    checks++; if (n != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (got[i] !== vexp[i]) begin errors++; $display("FAIL b2b_data%0d got %h want %h", i, got[i], vexp[i]); end
      checks++; if (got_k[i] != 3 + i) begin errors++; $display("FAIL b2b_cycle%0d got %0d want %0d", i, got_k[i], 3 + i); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] bp_in [6];
    logic [15:0] bp_exp [6];
    logic [15:0] prev_dat;
    int tx, rx, stall_cnt;
    logic prev_stall, stall_now;
    bp_in = '{16'h3C00, 16'h3C40, 16'h4300, 16'hC300, 16'h3B80, 16'h7FC1};
    bp_exp = '{16'h3F80, 16'h4000, 16'h7F80, 16'hFF80, 16'h0000, 16'h7FC0};
    tx = 0; rx = 0; stall_cnt = 0; prev_stall = 1'b0; prev_dat = '0;
    for (int k = 1; k <= 60 && rx < 6; k++) begin
      @(negedge clk);
      out_ready = !(k >= 4 && k <= 8);
      #1;
      stall_now = out_valid && !out_ready;
      checks++; if (in_ready !== !stall_now) begin errors++; $display("FAIL bp_in_ready c%0d got %b want %b", k, in_ready, !stall_now); end
      checks++; if (inflight !== 2'(tx - rx)) begin errors++; $display("FAIL bp_inflight c%0d got %0d want %0d", k, inflight, tx - rx); end
      if (prev_stall && out_valid) begin
        checks++; if (out_data !== prev_dat) begin errors++; $display("FAIL bp_hold c%0d got %h want %h", k, out_data, prev_dat); end
      end
      if (stall_now) stall_cnt++;
      if (out_valid && out_ready) begin
        checks++; if (out_data !== bp_exp[rx]) begin errors++; $display("FAIL bp_data%0d got %h want %h", rx, out_data, bp_exp[rx]); end
        rx++;
      end
      prev_stall = stall_now; prev_dat = out_data;
      if (tx < 6 && in_ready) begin in_valid = 1'b1; in_data = bp_in[tx]; tx++; end
      else in_valid = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (rx != 6) begin errors++; $display("FAIL bp_count got %0d want 6", rx); end
    checks++; if (stall_cnt != 5) begin errors++; $display("FAIL bp_stall_cycles got %0d want 5", stall_cnt); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_inflight_write();
    logic [15:0] d;
    d = 16'hxxxx;
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h3C00;
    cfg_w_en = 1'b1; cfg_sgn = 1'b0; cfg_idx = 4'd0; cfg_base = 16'h4000; cfg_offset = 16'h0100;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin in_valid = 1'b0; cfg_w_en = 1'b0; end
      if (out_valid) begin d = out_data; break; end
    end
    checks++; if (d !== 16'h4000) begin errors++; $display("FAIL inflight_write got %h want 4000", d); end
    wr(1'b0, 4'd0, 16'h3F80, 16'h0100);
  endtask

  task automatic test_reset_midflight();
    logic [15:0] d, dr; int lat, seen;
    out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_data = 16'h3C00;
    @(negedge clk); in_data = 16'h3C40;
    @(negedge clk); in_data = 16'h4300;
    @(negedge clk); in_valid = 1'b0;
    checks++; if (inflight !== 2'd3) begin errors++; $display("FAIL mid_full got %0d want 3", inflight); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_stall_ready got %b want 0", in_ready); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b want 0", out_valid); end
    checks++; if (inflight !== 2'd0) begin errors++; $display("FAIL mid_inflight got %0d want 0", inflight); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b want 1", in_ready); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL mid_out_data got %h want 0000", out_data); end
    seen = 0;
    repeat (6) begin @(negedge clk); if (out_valid) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL mid_emitted got %0d want 0", seen); end
    run_beat(16'h3C00, d, dr, lat);
    checks++; if (d !== 16'h3F80) begin errors++; $display("FAIL mid_table_kept got %h want 3f80", d); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_w_en = 1'b0; cfg_sgn = 1'b0; cfg_idx = '0; cfg_base = '0; cfg_offset = '0;
    test_reset();
    test_basic();
    test_round();
    test_classes();
    test_idx_oob();
    test_back_to_back();
    test_backpressure();
    test_inflight_write();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
